// File: rtl/wbuffer_entry_ctrl.sv
// Write-buffer entry store: parks cache stores by allocator tag, issues them in order, frees tags on response.
// Optional store merging into PENDING entries is enabled with `define WBUF_MERGE_EN.
module wbuffer_entry_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ENTRIES = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W/8-1:0] st_strb,
    input  logic                tag_valid,
    input  logic [7:0]          tag,
    output logic                tag_enable,
    output logic [255:0]        tag_free,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [7:0]          mem_req_id,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic [DATA_W/8-1:0] mem_req_strb,
    input  logic                mem_rsp_valid,
    input  logic [7:0]          mem_rsp_id,
    output logic                wb_empty,
    output logic                err_unexp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned PTR_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        E_FREE     = 2'd0,
        E_PENDING  = 2'd1,
        E_INFLIGHT = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } entry_t;

    entry_state_e       state_q [ENTRIES];
    entry_state_e       state_d [ENTRIES];
    entry_t             ent_q   [ENTRIES];
    entry_t             ent_d   [ENTRIES];
    logic [IDX_W-1:0]   fifo_q  [ENTRIES];
    logic [IDX_W-1:0]   fifo_d  [ENTRIES];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [255:0]       tag_free_q, tag_free_d;
    logic               err_q, err_d;

    logic               fifo_empty;
    logic               issue;
    logic               accept;
    logic               tag_in_range;
    logic               rsp_in_range;
    logic               busy;
    logic               merge_hit;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   tag_idx;
    logic [IDX_W-1:0]   rsp_idx;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign head_idx     = fifo_q[rd_ptr_q[IDX_W-1:0]];
    assign tag_idx      = tag[IDX_W-1:0];
    assign rsp_idx      = mem_rsp_id[IDX_W-1:0];
    assign tag_in_range = ({1'b0, tag} < 9'(ENTRIES));
    assign rsp_in_range = ({1'b0, mem_rsp_id} < 9'(ENTRIES));

    assign mem_req_valid = !fifo_empty;
    assign mem_req_id    = 8'(head_idx);
    assign mem_req_addr  = ent_q[head_idx].addr;
    assign mem_req_data  = ent_q[head_idx].data;
    assign mem_req_strb  = ent_q[head_idx].strb;
    assign issue         = mem_req_valid && mem_req_ready;

    // A merge hit absorbs the store without consuming a tag
    assign st_ready   = tag_valid || merge_hit;
    assign tag_enable = st_valid && tag_valid && !merge_hit;
    assign accept     = tag_enable;

`ifdef WBUF_MERGE_EN
    logic [IDX_W-1:0] merge_idx;

    // Descending scan so the lowest matching index wins; the entry leaving this cycle is excluded
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == E_PENDING
                && ent_q[i].addr[ADDR_W-1:2] == st_addr[ADDR_W-1:2]
                && !(issue && head_idx == IDX_W'(i))) begin
                merge_hit = 1'b1;
                merge_idx = IDX_W'(i);
            end
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_free_d = '0;
        err_d      = err_q;

        if (mem_rsp_valid) begin
            if (rsp_in_range && state_q[rsp_idx] == E_INFLIGHT) begin
                state_d[rsp_idx]       = E_FREE;
                tag_free_d[mem_rsp_id] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (issue) begin
            state_d[head_idx] = E_INFLIGHT;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        // Tag is consumed even when rejected; only a clean allocation writes and enqueues
        if (accept) begin
            if (tag_in_range && state_q[tag_idx] == E_FREE) begin
                state_d[tag_idx]                 = E_PENDING;
                ent_d[tag_idx]                   = '{st_addr, st_data, st_strb};
                fifo_d[wr_ptr_q[IDX_W-1:0]]      = tag_idx;
                wr_ptr_d                         = wr_ptr_q + PTR_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef WBUF_MERGE_EN
        if (st_valid && merge_hit) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (st_strb[b]) begin
                    ent_d[merge_idx].data[8*b +: 8] = st_data[8*b +: 8];
                end
            end
            ent_d[merge_idx].strb = ent_q[merge_idx].strb | st_strb;
        end
`endif
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (state_q[i] != E_FREE) begin
                busy = 1'b1;
            end
        end
    end

    assign wb_empty  = !busy && (tag_free_q == '0);
    assign tag_free  = tag_free_q;
    assign err_unexp = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                state_q[i] <= E_FREE;
                ent_q[i]   <= '0;
                fifo_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_free_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ent_q      <= ent_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_free_q <= tag_free_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_wbuffer_entry_ctrl.sv
// Directed bench for wbuffer_entry_ctrl: accept/issue/response ordering, tag freeing, errors and reset.
module tb_wbuffer_entry_ctrl;

    logic         clk = 1'b0;
    logic         rstn;
    logic         st_valid;
    logic         st_ready;
    logic [31:0]  st_addr;
    logic [31:0]  st_data;
    logic [3:0]   st_strb;
    logic         tag_valid;
    logic [7:0]   tag;
    logic         tag_enable;
    logic [255:0] tag_free;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [7:0]   mem_req_id;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_data;
    logic [3:0]   mem_req_strb;
    logic         mem_rsp_valid;
    logic [7:0]   mem_rsp_id;
    logic         wb_empty;
    logic         err_unexp;

    int n_tests = 0;
    int n_fail  = 0;

    wbuffer_entry_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_strb       (st_strb),
        .tag_valid     (tag_valid),
        .tag           (tag),
        .tag_enable    (tag_enable),
        .tag_free      (tag_free),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_id    (mem_req_id),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_strb  (mem_req_strb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_id    (mem_rsp_id),
        .wb_empty      (wb_empty),
        .err_unexp     (err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [7:0] t);
        st_valid  = 1'b1;
        tag_valid = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_strb   = s;
        tag       = t;
        #1;
    endtask

    task automatic clear_store();
        st_valid  = 1'b0;
        tag_valid = 1'b0;
    endtask

    function automatic logic [255:0] onehot(input int b);
        logic [255:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        rstn = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_strb = '0;
        tag_valid = 1'b0; tag = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_id = '0;
        tick(); tick();
        chk("rst_st_ready", 256'(st_ready), 256'(0));
        chk("rst_tag_enable", 256'(tag_enable), 256'(0));
        chk("rst_tag_free", tag_free, '0);
        chk("rst_mem_req_valid", 256'(mem_req_valid), 256'(0));
        chk("rst_wb_empty", 256'(wb_empty), 256'(1));
        chk("rst_err", 256'(err_unexp), 256'(0));
        rstn = 1'b1;
        tick();

        // 1: single store through to tag_free
        drive_store(32'h100, 32'hDEADBEEF, 4'hF, 8'd5);
        chk("t1_tag_enable", 256'(tag_enable), 256'(1));
        chk("t1_no_bypass", 256'(mem_req_valid), 256'(0));
        tick(); clear_store();
        chk("t1_req_valid", 256'(mem_req_valid), 256'(1));
        chk("t1_req_id", 256'(mem_req_id), 256'(5));
        chk("t1_req_addr", 256'(mem_req_addr), 256'(32'h100));
        chk("t1_req_data", 256'(mem_req_data), 256'(32'hDEADBEEF));
        chk("t1_req_strb", 256'(mem_req_strb), 256'(4'hF));
        chk("t1_not_empty", 256'(wb_empty), 256'(0));
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        chk("t1_popped", 256'(mem_req_valid), 256'(0));
        mem_rsp_valid = 1'b1; mem_rsp_id = 8'd5;
        tick(); mem_rsp_valid = 1'b0;
        chk("t1_tag_free", tag_free, onehot(5));
        chk("t1_empty_during_pulse", 256'(wb_empty), 256'(0));
        tick();
        chk("t1_tag_free_off", tag_free, '0);
        chk("t1_empty", 256'(wb_empty), 256'(1));

        // 2: backpressure holds head stable, then in-order issue
        drive_store(32'h10, 32'h11, 4'hF, 8'd1); tick();
        chk("t2_id_a", 256'(mem_req_id), 256'(1));
        drive_store(32'h20, 32'h22, 4'hF, 8'd2); tick();
        chk("t2_id_b", 256'(mem_req_id), 256'(1));
        drive_store(32'h30, 32'h33, 4'hF, 8'd3); tick(); clear_store();
        chk("t2_id_c", 256'(mem_req_id), 256'(1));
        chk("t2_addr_stable", 256'(mem_req_addr), 256'(32'h10));
        chk("t2_data_stable", 256'(mem_req_data), 256'(32'h11));
        mem_req_ready = 1'b1;
        #1;
        chk("t2_issue1", 256'(mem_req_id), 256'(1));
        tick();
        chk("t2_issue2", 256'(mem_req_id), 256'(2));
        chk("t2_issue2_addr", 256'(mem_req_addr), 256'(32'h20));
        tick();
        chk("t2_issue3", 256'(mem_req_id), 256'(3));
        chk("t2_issue3_data", 256'(mem_req_data), 256'(32'h33));
        tick(); mem_req_ready = 1'b0;
        chk("t2_drained", 256'(mem_req_valid), 256'(0));

        // 3: out-of-order responses 3,1,2
        mem_rsp_valid = 1'b1; mem_rsp_id = 8'd3; tick();
        chk("t3_free3", tag_free, onehot(3));
        mem_rsp_id = 8'd1; tick();
        chk("t3_free1", tag_free, onehot(1));
        mem_rsp_id = 8'd2; tick(); mem_rsp_valid = 1'b0;
        chk("t3_free2", tag_free, onehot(2));
        tick();
        chk("t3_free_off", tag_free, '0);
        chk("t3_empty", 256'(wb_empty), 256'(1));
        chk("t3_no_err", 256'(err_unexp), 256'(0));

        // 4: no tag available -> no accept until tag_valid rises
        drive_store(32'h60, 32'h66, 4'hF, 8'd6);
        tag_valid = 1'b0;
        #1;
        chk("t4_st_ready_low", 256'(st_ready), 256'(0));
        chk("t4_tag_enable_low", 256'(tag_enable), 256'(0));
        tick();
        chk("t4_nothing_queued", 256'(mem_req_valid), 256'(0));
        tag_valid = 1'b1;
        #1;
        chk("t4_st_ready_high", 256'(st_ready), 256'(1));
        chk("t4_tag_enable_high", 256'(tag_enable), 256'(1));
        tick(); clear_store();
        chk("t4_queued", 256'(mem_req_id), 256'(6));

        // 5: accept + issue + response in the same cycle
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        drive_store(32'h20, 32'h2222, 4'hF, 8'd2); tick(); clear_store();
        drive_store(32'h40, 32'h4444, 4'hF, 8'd4);
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_id = 8'd6;
        #1;
        chk("t5_tag_enable", 256'(tag_enable), 256'(1));
        chk("t5_head", 256'(mem_req_id), 256'(2));
        tick(); clear_store(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        chk("t5_free6", tag_free, onehot(6));
        chk("t5_new_head", 256'(mem_req_id), 256'(4));
        chk("t5_new_head_data", 256'(mem_req_data), 256'(32'h4444));
        chk("t5_no_err", 256'(err_unexp), 256'(0));
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        chk("t5_count_one", 256'(mem_req_valid), 256'(0));
        mem_rsp_valid = 1'b1; mem_rsp_id = 8'd2; tick();
        chk("t5_free2", tag_free, onehot(2));
        mem_rsp_id = 8'd4; tick(); mem_rsp_valid = 1'b0;
        chk("t5_free4", tag_free, onehot(4));
        tick();
        chk("t5_empty", 256'(wb_empty), 256'(1));

        // 7: two stores to the same word with issue stalled
        drive_store(32'h200, 32'h0000AAAA, 4'h3, 8'd8);
        chk("t7_first_enable", 256'(tag_enable), 256'(1));
        tick();
        drive_store(32'h200, 32'hBBBB0000, 4'hC, 8'd9);
`ifdef WBUF_MERGE_EN
        chk("t7_second_enable", 256'(tag_enable), 256'(0));
        chk("t7_second_ready", 256'(st_ready), 256'(1));
`else
        chk("t7_second_enable", 256'(tag_enable), 256'(1));
`endif
        tick(); clear_store();
        chk("t7_head_id", 256'(mem_req_id), 256'(8));
`ifdef WBUF_MERGE_EN
        chk("t7_merged_data", 256'(mem_req_data), 256'(32'hBBBBAAAA));
        chk("t7_merged_strb", 256'(mem_req_strb), 256'(4'hF));
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        chk("t7_single_issue", 256'(mem_req_valid), 256'(0));
`else
        chk("t7_first_data", 256'(mem_req_data), 256'(32'h0000AAAA));
        chk("t7_first_strb", 256'(mem_req_strb), 256'(4'h3));
        mem_req_ready = 1'b1; tick();
        chk("t7_second_id", 256'(mem_req_id), 256'(9));
        chk("t7_second_data", 256'(mem_req_data), 256'(32'hBBBB0000));
        chk("t7_second_strb", 256'(mem_req_strb), 256'(4'hC));
        tick(); mem_req_ready = 1'b0;
        chk("t7_drained", 256'(mem_req_valid), 256'(0));
`endif

        // 6: unexpected response, sticky error, reset mid-traffic, out-of-range tag
        mem_rsp_valid = 1'b1; mem_rsp_id = 8'd7; tick(); mem_rsp_valid = 1'b0;
        chk("t6_err_set", 256'(err_unexp), 256'(1));
        tick(); tick();
        chk("t6_err_sticky", 256'(err_unexp), 256'(1));
        drive_store(32'h300, 32'h3, 4'hF, 8'd10); tick(); clear_store();
        rstn = 1'b0;
        #1;
        chk("t6_rst_async_err", 256'(err_unexp), 256'(0));
        chk("t6_rst_async_valid", 256'(mem_req_valid), 256'(0));
        chk("t6_rst_async_empty", 256'(wb_empty), 256'(1));
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_rst_no_free", tag_free, '0);
        mem_rsp_valid = 1'b1; mem_rsp_id = 8'd10; tick(); mem_rsp_valid = 1'b0;
        chk("t6_stale_rsp_err", 256'(err_unexp), 256'(1));
        chk("t6_stale_no_free", tag_free, '0);
        rstn = 1'b0; #1; rstn = 1'b1;
        tick();
        drive_store(32'h400, 32'h4, 4'hF, 8'd40);
        chk("t6_oor_consumed", 256'(tag_enable), 256'(1));
        tick(); clear_store();
        chk("t6_oor_err", 256'(err_unexp), 256'(1));
        chk("t6_oor_not_queued", 256'(mem_req_valid), 256'(0));
        chk("t6_oor_empty", 256'(wb_empty), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
